// File: rtl/uart_receiver.sv
// 8N1 UART receiver clocked at 16x the bit rate. It votes three mid-bit samples
// per bit and hands finished bytes to a FIFO, flagging framing and overrun errors.
module uart_receiver (
    input  logic       uart_clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    input  logic       rf_full,
    output logic [7:0] rf_data,
    output logic       rf_wrreq,
    output logic       frame_err,
    output logic       overrun_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } state_t;

    state_t     state, state_nxt;
    logic       rxd_meta, rxd_s;
    logic [3:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] sr;
    logic       samp7, samp8;
    logic       majority, decision;
    logic       cnt_clr, shift_en, idx_clr, idx_inc;
    logic       wr_nxt, ferr_nxt, oerr_nxt;

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Samples at cnt 7 and 8 are held so the vote completes in the cnt 9 cycle.
    assign majority = (samp7 & samp8) | (samp7 & rxd_s) | (samp8 & rxd_s);
    assign decision = (cnt == 4'd9);

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        wr_nxt    = 1'b0;
        ferr_nxt  = 1'b0;
        oerr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_nxt = START;
                    cnt_clr   = 1'b1;
                end
            end
            START: begin
                if (decision && majority) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd15) begin
                    state_nxt = DATA;
                    idx_clr   = 1'b1;
                end
            end
            DATA: begin
                shift_en = decision;
                if (cnt == 4'd15) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (decision) begin
                    if (majority) begin
                        state_nxt = IDLE;
                        if (rf_full) begin
                            oerr_nxt = 1'b1;
                        end else begin
                            wr_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = BRK_WAIT;
                        ferr_nxt  = 1'b1;
                    end
                end
            end
            BRK_WAIT: begin
                if (rxd_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            bit_idx <= 3'd0;
            sr      <= 8'h00;
            samp7   <= 1'b1;
            samp8   <= 1'b1;
        end else begin
            if (cnt_clr) begin
                cnt <= 4'd0;
            end else if (state != IDLE && state != BRK_WAIT) begin
                cnt <= cnt + 4'd1;
            end
            if (cnt == 4'd7) begin
                samp7 <= rxd_s;
            end
            if (cnt == 4'd8) begin
                samp8 <= rxd_s;
            end
            if (idx_clr) begin
                bit_idx <= 3'd0;
            end else if (idx_inc) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                sr <= {majority, sr[7:1]};
            end
        end
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_data     <= 8'h00;
            rf_wrreq    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rf_wrreq    <= wr_nxt;
            frame_err   <= ferr_nxt;
            overrun_err <= oerr_nxt;
            if (wr_nxt) begin
                rf_data <= sr;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver. Each frame pushes its expected outcome
// and timing onto a queue, and a monitor pops and compares it when a pulse appears.
module tb_uart_receiver;

    logic       uart_clk = 1'b0;
    logic       rst_n    = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       rf_full  = 1'b0;
    logic [7:0] rf_data;
    logic       rf_wrreq;
    logic       frame_err;
    logic       overrun_err;

    uart_receiver dut (
        .uart_clk    (uart_clk),
        .rst_n       (rst_n),
        .uart_rxd    (uart_rxd),
        .rf_full     (rf_full),
        .rf_data     (rf_data),
        .rf_wrreq    (rf_wrreq),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 uart_clk = ~uart_clk;

    int cyc = 0;
    always @(posedge uart_clk) cyc <= cyc + 1;

    // kind is one-hot {overrun_err, frame_err, rf_wrreq}
    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         start_cyc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_data = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // full_mode: 0 = rf_full low, 1 = rf_full high throughout,
    // 2 = rf_full high except around the stop-bit decision
    task automatic applyStimulus(input logic [7:0] d, input logic stop_bit,
                                 input int glitch_idx, input int full_mode);
        exp_t       e;
        logic [9:0] frame;
        int         bit_pos;
        frame = {stop_bit, d, 1'b0};
        @(negedge uart_clk);
        e.start_cyc = cyc;
        if (!stop_bit) begin
            e.kind = 3'b010;
            e.data = last_data;
        end else if (full_mode == 1) begin
            e.kind = 3'b100;
            e.data = last_data;
        end else begin
            e.kind    = 3'b001;
            e.data    = d;
            last_data = d;
        end
        sb.push_back(e);
        for (int k = 0; k < 160; k++) begin
            if (k > 0) @(negedge uart_clk);
            bit_pos  = k / 16;
            uart_rxd = frame[bit_pos[3:0]] ^ (k == glitch_idx);
            rf_full  = (full_mode == 1) || (full_mode == 2 && k < 150);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge uart_clk);
            uart_rxd = 1'b1;
            rf_full  = 1'b0;
        end
    endtask

    always @(negedge uart_clk) begin
        exp_t e;
        int   pulses;
        if (rst_n && (rf_wrreq || frame_err || overrun_err)) begin
            pulses = int'(rf_wrreq) + int'(frame_err) + int'(overrun_err);
            checkOutput("one_hot", pulses, 1);
            if (sb.size() == 0) begin
                checkOutput("spurious_pulse", {29'd0, overrun_err, frame_err, rf_wrreq}, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("kind", {29'd0, overrun_err, frame_err, rf_wrreq}, {29'd0, e.kind});
                checkOutput("rf_data", {24'd0, rf_data}, {24'd0, e.data});
                checkOutput("latency", cyc - e.start_cyc, 157);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Async reset must act before the first clock edge at t=5.
        #2 rst_n = 1'b0;
        #2;
        checkOutput("reset_rf_data", {24'd0, rf_data}, 32'h00);
        checkOutput("reset_rf_wrreq", {31'd0, rf_wrreq}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_overrun_err", {31'd0, overrun_err}, 32'd0);
        repeat (3) @(negedge uart_clk);
        rst_n = 1'b1;
        idleCycles(10);

        applyStimulus(8'h55, 1'b1, -1, 0);
        idleCycles(20);

        // Short low glitch must be rejected as a false start.
        for (int k = 0; k < 5; k++) begin
            @(negedge uart_clk);
            uart_rxd = 1'b0;
        end
        idleCycles(30);

        // Framing error followed by a held break.
        applyStimulus(8'hA3, 1'b0, -1, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge uart_clk);
            uart_rxd = 1'b0;
        end
        idleCycles(30);

        applyStimulus(8'h3C, 1'b1, -1, 1);
        idleCycles(10);

        // Line index 57 lands on the cnt=8 sample of data bit 2.
        applyStimulus(8'h00, 1'b1, 57, 0);
        applyStimulus(8'h5A, 1'b1, -1, 2);
        applyStimulus(8'($urandom_range(0, 255)), 1'b1, -1, 0);
        applyStimulus(8'($urandom_range(0, 255)), 1'b1, -1, 0);
        idleCycles(10);

        // Reset in the middle of data bit 4 aborts the frame silently.
        for (int k = 0; k < 85; k++) begin
            @(negedge uart_clk);
            uart_rxd = (k < 16) ? 1'b0 : k[4];
        end
        rst_n = 1'b0;
        #2;
        checkOutput("midframe_reset_rf_data", {24'd0, rf_data}, 32'h00);
        checkOutput("midframe_reset_rf_wrreq", {31'd0, rf_wrreq}, 32'd0);
        last_data = 8'h00;
        repeat (3) @(negedge uart_clk);
        uart_rxd = 1'b1;
        rst_n    = 1'b1;
        idleCycles(20);
        applyStimulus(8'h81, 1'b1, -1, 0);
        applyStimulus(8'hFF, 1'b1, -1, 0);
        idleCycles(5);

        for (int k = 0; k < 400 && sb.size() != 0; k++) begin
            @(negedge uart_clk);
        end
        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        idleCycles(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have these ports, clock and reset first; reset rst_n, asynchronous, active-low; clock uart_clk:
REQ-002 uart_clk  input  1  16x oversampling clock, 16 cycles per bit.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 uart_rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 rf_full  input  1  receive FIFO full flag, sampled in the decision cycle.
REQ-006 rf_data  output  8  received byte, registered, held until the next write.
REQ-007 rf_wrreq  output  1  one-cycle FIFO write strobe; rf_data valid in the same cycle.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled 0.
REQ-009 overrun_err  output  1  one-cycle pulse: good byte dropped because rf_full=1.

Function
REQ-010 uart_rxd SHALL pass through a 2-flop synchronizer (rxd_s); both flops reset to 1.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, BRK_WAIT.
REQ-012 A 4-bit sample counter cnt SHALL be cleared on entry to START and increment every cycle outside IDLE/BRK_WAIT, wrapping 15->0.
REQ-013 Bit value SHALL be the majority of rxd_s at cnt=7, 8 and 9; the decision cycle is cnt=9.
REQ-014 IDLE: rxd_s=0 SHALL move to START with cnt=0 (this edge is T0); otherwise stay.
REQ-015 START: majority=1 at cnt=9 SHALL be a false start, returning to IDLE with no output activity; otherwise at cnt=15 move to DATA, bit index=0.
REQ-016 DATA: at cnt=9 shift register SHALL load {bit, sr[7:1]} (LSB first); at cnt=15 move to STOP if index=7, else increment the index.
REQ-017 STOP, decision cycle, majority=1, rf_full=0: SHALL drive rf_data<=sr and rf_wrreq=1 for exactly one cycle, then go to IDLE.
REQ-018 STOP, majority=1, rf_full=1: SHALL pulse overrun_err one cycle, leave rf_data unchanged, assert no rf_wrreq, then go to IDLE.
REQ-019 STOP, majority=0: SHALL pulse frame_err one cycle, assert no rf_wrreq, then go to BRK_WAIT.
REQ-020 BRK_WAIT SHALL remain until rxd_s=1, then go to IDLE; no start detection while in BRK_WAIT.
REQ-021 Latency: rf_wrreq/frame_err/overrun_err SHALL be high in the cycle registered at T0+154, i.e. STOP cnt=9 at T0+153 plus one register stage.
REQ-022 The return to IDLE at stop-bit mid-point SHALL allow a following start bit to be detected with no lost frames at back-to-back rate (10 bits, 160 cycles).
REQ-023 At most one of rf_wrreq, frame_err, overrun_err SHALL be high in any cycle.
REQ-024 rf_full SHALL be sampled only in the STOP decision cycle; changes at other times have no effect.

Reset
REQ-025 On rst_n=0, without waiting for a clock edge: state=IDLE, cnt=0, index=0, sr=0x00, rf_data=0x00, rf_wrreq=0, frame_err=0, overrun_err=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release the next clean frame SHALL be received correctly.

Verification
REQ-027 Frame 0x55, 16 cycles/bit, rf_full=0 -> single rf_wrreq pulse, rf_data=0x55, no error pulses.
REQ-028 Idle line with a 5-cycle low glitch -> no rf_wrreq, no error pulse, FSM back in IDLE by T0+10.
REQ-029 Frame 0xA3 with stop bit 0, line held low 40 more cycles, then high -> one frame_err pulse, no rf_wrreq, no new START until rxd_s=1.
REQ-030 Frame 0x3C with rf_full=1 -> one overrun_err pulse, no rf_wrreq, rf_data keeps its previous value.
REQ-031 Frame 0x00 with bit 2 inverted for the single cycle at cnt=8 -> rf_data=0x00 (majority vote corrects).
REQ-032 Reset pulse at bit 4 of a frame, then back-to-back frames 0x81, 0xFF -> two rf_wrreq pulses 160 cycles apart, data 0x81 then 0xFF.
